encoder_transmitter: RTL

ENCODER_TRANSMITTER -- requirements
Module: Encoder_Transmitter

---
 rtl/encoder_transmitter_pkg.sv | 34 +++
 rtl/encoder_transmitter_packer.sv | 74 +++++++
 rtl/encoder_transmitter.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/encoder_transmitter_pkg.sv
// ============================================================================
// encoder_transmitter_pkg : shared IO definitions for the encoder/decoder pair
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

package encoder_transmitter_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_HDR_SIZE = 3'd1,
    S_HDR_ROWS = 3'd2,
    S_FETCH    = 3'd3,
    S_WAIT_MEM = 3'd4,
    S_SCAN     = 3'd5,
    S_FLUSH    = 3'd6,
    S_DONE     = 3'd7
  } tx_state_t;

  function automatic bit packet_size_ok(input int p);
    return (p == 4) || (p == 8) || (p == 16);
  endfunction

  function automatic logic [31:0] hdr_size_word(input int p);
    return {26'b0, 6'(p)};
  endfunction

  function automatic logic [31:0] hdr_rows_word(input logic [15:0] rows);
    return {16'b0, rows};
  endfunction

endpackage

`default_nettype wire

// File: rtl/encoder_transmitter_packer.sv
// ============================================================================
// encoder_transmitter_packer : packs small packets MSB-first into 32-bit words
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module encoder_transmitter_packer #(
  parameter int PACKET_SIZE = 8
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   pkt_valid,
  input  logic [PACKET_SIZE-1:0] pkt_data,
  input  logic                   word_load,
  input  logic [31:0]            word_data,
  input  logic                   flush,
  input  logic                   bus_ready,
  output logic [31:0]            cpu_bus,
  output logic                   bus_valid,
  output logic                   empty
);

  localparam int C_SLOTS = 32 / PACKET_SIZE;
  localparam int C_SW    = $clog2(C_SLOTS + 1);
  localparam logic [C_SW-1:0] C_LAST = C_SW'(C_SLOTS - 1);

  logic [31:0]     r_acc;
  logic [C_SW-1:0] r_slots;
  logic [31:0]     r_bus;
  logic            r_valid;
  logic [31:0]     w_acc_next;
  logic [5:0]      w_pad_bits;
  logic            w_full;

  assign w_acc_next = {r_acc[31-PACKET_SIZE:0], pkt_data};
  assign w_full     = pkt_valid && (r_slots == C_LAST);
  // A partial word is left-aligned so unused trailing slots read as zero.
  assign w_pad_bits = 6'((C_SLOTS - int'(r_slots)) * PACKET_SIZE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_acc   <= '0;
      r_slots <= '0;
      r_bus   <= '0;
      r_valid <= 1'b0;
    end else begin
      if (r_valid && bus_ready) r_valid <= 1'b0;
      if (word_load) begin
        r_bus   <= word_data;
        r_valid <= 1'b1;
      end else if (w_full) begin
        r_bus   <= w_acc_next;
        r_valid <= 1'b1;
        r_acc   <= '0;
        r_slots <= '0;
      end else if (pkt_valid) begin
        r_acc   <= w_acc_next;
        r_slots <= r_slots + 1'b1;
      end else if (flush && (r_slots != '0)) begin
        r_bus   <= r_acc << w_pad_bits;
        r_valid <= 1'b1;
        r_acc   <= '0;
        r_slots <= '0;
      end
    end
  end

  assign cpu_bus   = r_bus;
  assign bus_valid = r_valid;
  assign empty     = (r_slots == '0);

endmodule

`default_nettype wire

// File: rtl/encoder_transmitter.sv
// ============================================================================
// encoder_transmitter : run-length encodes RAM rows into a 32-bit word stream
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module encoder_transmitter
  import encoder_transmitter_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 13,
  parameter int DATA_WIDTH    = 64,
  parameter int PACKET_SIZE   = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     Start,
  input  logic [15:0]              Rows_Num,
  input  logic [7:0]               Row_Words,
  output logic [ADDRESS_WIDTH-1:0] RAM_Address,
  output logic                     RAM_Read,
  input  logic [DATA_WIDTH-1:0]    RAM_Data,
  output logic [31:0]              CPU_Bus,
  output logic                     Out_Valid,
  input  logic                     Out_Ready,
  output logic                     Busy,
  output logic                     Done_Sending
);

  localparam int C_BW = $clog2(DATA_WIDTH);
  localparam int C_LW = PACKET_SIZE - 1;
  localparam logic [C_LW-1:0] C_MAX = '1;

  if (!packet_size_ok(PACKET_SIZE)) begin : g_bad_packet_size
    $error("encoder_transmitter: PACKET_SIZE must be 4, 8 or 16");
  end

  tx_state_t r_state, w_next;
  logic [15:0]              r_rows, r_row;
  logic [7:0]               r_row_words, r_wir;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0]    r_shift;
  logic [C_BW-1:0]          r_bit;
  logic [C_LW-1:0]          r_cnt, w_cnt_next, w_pkt_len;
  logic                     r_val, w_val_next;
  logic [1:0]               r_sub, w_sub_next;
  logic                     w_stall, w_bit, w_last_word, w_last_row;
  logic                     w_pkt_valid, w_word_load, w_flush, w_pk_empty;
  logic                     w_consume, w_row_end;
  logic [31:0]              w_word;

  assign w_stall     = Out_Valid && !Out_Ready;
  assign w_bit       = r_shift[DATA_WIDTH-1];
  assign w_last_word = (r_wir == r_row_words - 8'd1);
  assign w_last_row  = (r_row == r_rows - 16'd1);

  // r_sub sequences the extra packets one bit can produce: 1 = zero-length
  // packet after a MAX run, 2 = row-end emit of the pending run.
  always_comb begin
    w_next      = r_state;
    w_pkt_valid = 1'b0;
    w_pkt_len   = '0;
    w_word_load = 1'b0;
    w_word      = '0;
    w_flush     = 1'b0;
    w_consume   = 1'b0;
    w_row_end   = 1'b0;
    w_sub_next  = r_sub;
    w_cnt_next  = r_cnt;
    w_val_next  = r_val;
    case (r_state)
      S_IDLE: begin
        w_sub_next = 2'd0;
        w_cnt_next = '0;
        w_val_next = 1'b0;
        if (Start) w_next = S_HDR_SIZE;
      end
      S_HDR_SIZE: if (!w_stall) begin
        w_word_load = 1'b1;
        w_word      = hdr_size_word(PACKET_SIZE);
        w_next      = S_HDR_ROWS;
      end
      S_HDR_ROWS: if (!w_stall) begin
        w_word_load = 1'b1;
        w_word      = hdr_rows_word(r_rows);
        w_next      = ((r_rows == '0) || (r_row_words == '0)) ? S_FLUSH : S_FETCH;
      end
      S_FETCH: if (!w_stall) w_next = S_WAIT_MEM;
      S_WAIT_MEM: w_next = S_SCAN;
      S_SCAN: if (!w_stall) begin
        case (r_sub)
          2'd0: begin
            if ((w_bit == r_val) && (r_cnt == C_MAX)) begin
              w_pkt_valid = 1'b1;
              w_pkt_len   = C_MAX;
              w_sub_next  = 2'd1;
            end else begin
              w_consume = 1'b1;
              if (w_bit == r_val) begin
                w_cnt_next = r_cnt + 1'b1;
              end else begin
                w_pkt_valid = 1'b1;
                w_pkt_len   = r_cnt;
                w_val_next  = w_bit;
                w_cnt_next  = C_LW'(1);
              end
            end
          end
          2'd1: begin
            w_pkt_valid = 1'b1;
            w_pkt_len   = '0;
            w_cnt_next  = C_LW'(1);
            w_sub_next  = 2'd0;
            w_consume   = 1'b1;
          end
          default: begin
            w_pkt_valid = 1'b1;
            w_pkt_len   = r_cnt;
            w_row_end   = 1'b1;
            w_val_next  = 1'b0;
            w_cnt_next  = '0;
            w_sub_next  = 2'd0;
            w_next      = w_last_row ? S_FLUSH : S_FETCH;
          end
        endcase
        if (w_consume && (r_bit == '0)) begin
          if (w_last_word) w_sub_next = 2'd2;
          else             w_next     = S_FETCH;
        end
      end
      S_FLUSH: if (!w_stall) begin
        if (!w_pk_empty)     w_flush = 1'b1;
        else if (!Out_Valid) w_next  = S_DONE;
      end
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_rows      <= '0;
      r_row_words <= '0;
      r_row       <= '0;
      r_wir       <= '0;
      r_addr      <= '0;
      r_shift     <= '0;
      r_bit       <= '0;
      r_cnt       <= '0;
      r_val       <= 1'b0;
      r_sub       <= 2'd0;
    end else begin
      r_state <= w_next;
      r_sub   <= w_sub_next;
      r_cnt   <= w_cnt_next;
      r_val   <= w_val_next;
      if ((r_state == S_IDLE) && Start) begin
        r_rows      <= Rows_Num;
        r_row_words <= Row_Words;
        r_row       <= '0;
        r_wir       <= '0;
        r_addr      <= '0;
      end
      if (RAM_Read) r_addr <= r_addr + 1'b1;
      if (r_state == S_WAIT_MEM) begin
        r_shift <= RAM_Data;
        r_bit   <= C_BW'(DATA_WIDTH - 1);
      end
      if (w_consume) begin
        r_shift <= {r_shift[DATA_WIDTH-2:0], 1'b0};
        r_bit   <= r_bit - 1'b1;
        if ((r_bit == '0) && !w_last_word) r_wir <= r_wir + 1'b1;
      end
      if (w_row_end) begin
        r_wir <= '0;
        r_row <= r_row + 1'b1;
      end
    end
  end

  encoder_transmitter_packer #(
    .PACKET_SIZE (PACKET_SIZE)
  ) u_packer (
    .CLK       (CLK),
    .RST       (RST),
    .pkt_valid (w_pkt_valid),
    .pkt_data  ({r_row[0], w_pkt_len}),
    .word_load (w_word_load),
    .word_data (w_word),
    .flush     (w_flush),
    .bus_ready (Out_Ready),
    .cpu_bus   (CPU_Bus),
    .bus_valid (Out_Valid),
    .empty     (w_pk_empty)
  );

  assign RAM_Address  = r_addr;
  assign RAM_Read     = (r_state == S_FETCH) && !w_stall;
  assign Busy         = (r_state != S_IDLE);
  assign Done_Sending = (r_state == S_DONE);

endmodule

`default_nettype wire
